// File: rtl/cmd_resp_ctrl.sv
// cmd_resp_ctrl: sequences UART commands to the application and returns an ACK/NAK response.
// Define CMD_RESP_ECHO_EN to append operand[15:8], operand[7:0] to every response.
module cmd_resp_ctrl #(
    parameter int         NUM_OPS     = 8,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter logic [7:0] NAK_BYTE    = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [23:0] cmd,
    output logic        clr_cmd_rdy,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        op_vld,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    input  logic        op_done,
    input  logic        op_err,
    output logic        op_abort,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT_OP,
        TX_LOAD,
        TX_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    status_q, status_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [15:0]   operand_q, operand_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          clr_q, clr_d;
    logic          trmt_q, trmt_d;
    logic          op_vld_q, op_vld_d;
    logic          op_abort_q, op_abort_d;
    logic          busy_q, busy_d;
    logic [7:0]    tx_byte;

`ifdef CMD_RESP_ECHO_EN
    logic [1:0] idx_q, idx_d;

    always_comb begin
        case (idx_q)
            2'd1:    tx_byte = operand_q[15:8];
            2'd2:    tx_byte = operand_q[7:0];
            default: tx_byte = status_q;
        endcase
    end
`else
    assign tx_byte = status_q;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        status_d   = status_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        tx_data_d  = tx_data_q;
        clr_d      = 1'b0;
        trmt_d     = 1'b0;
        op_vld_d   = 1'b0;
        op_abort_d = 1'b0;
`ifdef CMD_RESP_ECHO_EN
        idx_d      = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    opcode_d  = cmd[23:16];
                    operand_d = cmd[15:0];
                    clr_d     = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (int'(opcode_q) >= NUM_OPS) begin
                    status_d = NAK_BYTE;
                    state_d  = TX_LOAD;
                end else begin
                    op_vld_d = 1'b1;
                    timer_d  = '0;
                    state_d  = WAIT_OP;
                end
            end
            WAIT_OP: begin
                // a completion in the timeout cycle still counts as a completion
                if (op_done) begin
                    status_d = op_err ? NAK_BYTE : ACK_BYTE;
                    state_d  = TX_LOAD;
                end else if (timer_q == TMAX) begin
                    op_abort_d = 1'b1;
                    status_d   = NAK_BYTE;
                    state_d    = TX_LOAD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            TX_LOAD: begin
                tx_data_d = tx_byte;
                trmt_d    = 1'b1;
                state_d   = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
`ifdef CMD_RESP_ECHO_EN
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = TX_LOAD;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            status_q   <= 8'h00;
            opcode_q   <= 8'h00;
            operand_q  <= 16'h0000;
            tx_data_q  <= 8'h00;
            clr_q      <= 1'b0;
            trmt_q     <= 1'b0;
            op_vld_q   <= 1'b0;
            op_abort_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef CMD_RESP_ECHO_EN
            idx_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            tx_data_q  <= tx_data_d;
            clr_q      <= clr_d;
            trmt_q     <= trmt_d;
            op_vld_q   <= op_vld_d;
            op_abort_q <= op_abort_d;
            busy_q     <= busy_d;
`ifdef CMD_RESP_ECHO_EN
            idx_q      <= idx_d;
`endif
        end
    end

    assign clr_cmd_rdy = clr_q;
    assign trmt        = trmt_q;
    assign tx_data     = tx_data_q;
    assign op_vld      = op_vld_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign op_abort    = op_abort_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cmd_resp_ctrl.sv
// tb_cmd_resp_ctrl: scoreboard bench for cmd_resp_ctrl with a UART and application model.
// Honours CMD_RESP_ECHO_EN to expect 3-byte responses.
module tb_cmd_resp_ctrl;

`ifdef CMD_RESP_ECHO_EN
    localparam int NB = 3;
`else
    localparam int NB = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_rdy;
    logic [23:0] cmd;
    logic        clr_cmd_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        op_vld;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic        op_done;
    logic        op_err;
    logic        op_abort;
    logic        busy;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int n_clr = 0, n_vld = 0, n_abort = 0;
    int last_done_cyc = -100;
    logic [7:0] exp_q[$];

    cmd_resp_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .op_vld(op_vld), .opcode(opcode),
        .operand(operand), .op_done(op_done), .op_err(op_err),
        .op_abort(op_abort), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // UART transmitter: tx_done three cycles after trmt, dropped on reset
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt && rst_n) begin
                bit ok;
                ok = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (!rst_n) ok = 1'b0;
                end
                if (ok) begin
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_done) last_done_cyc = cyc;
            if (clr_cmd_rdy) n_clr++;
            if (op_vld) n_vld++;
            if (op_abort) n_abort++;
            if (trmt) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_extra: got byte %h, expected none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got %h, expected %h", tx_data, e);
                    end
                end
                vectors++;
                if (cyc - last_done_cyc < 2) begin
                    errors++;
                    $display("FAIL tx_gap: trmt %0d cycles after tx_done, expected >=2",
                             cyc - last_done_cyc);
                end
            end
        end
    end

    task automatic push_resp(input logic [7:0] st, input logic [15:0] opnd);
        exp_q.push_back(st);
        if (NB == 3) begin
            exp_q.push_back(opnd[15:8]);
            exp_q.push_back(opnd[7:0]);
        end
    endtask

    task automatic clear_counts();
        n_clr = 0;
        n_vld = 0;
        n_abort = 0;
    endtask

    task automatic send_cmd(input logic [23:0] c, output bit to);
        cmd = c;
        cmd_rdy = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) begin
                to = 1'b0;
                break;
            end
        end
        cmd_rdy = 1'b0;
    endtask

    task automatic wait_vld(output bit to, output int c);
        to = 1'b1;
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_vld) begin
                to = 1'b0;
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_done(input logic err);
        op_done = 1'b1;
        op_err = err;
        @(negedge clk);
        op_done = 1'b0;
        op_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_rdy = 1'b0;
        cmd = 24'h0;
        op_done = 1'b0;
        op_err = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({clr_cmd_rdy, trmt, op_vld, op_abort, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b, expected 00000",
                     {clr_cmd_rdy, trmt, op_vld, op_abort, busy});
        end
        vectors++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data: got %h, expected 00", tx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_legal_op();
        bit to;
        int vc;
        clear_counts();
        push_resp(8'hA5, 16'h1234);
        send_cmd(24'h031234, to);
        wait_vld(to, vc);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL legal_vld: got no op_vld, expected one");
        end
        vectors++;
        if ({opcode, operand} !== 24'h031234) begin
            errors++;
            $display("FAIL legal_latch: got %h, expected 031234", {opcode, operand});
        end
        repeat (4) @(negedge clk);
        pulse_done(1'b0);
        wait_idle(to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL legal_idle: %0d bytes outstanding, expected 0", exp_q.size());
        end
        vectors++;
        if (n_clr != 1 || n_vld != 1 || n_abort != 0) begin
            errors++;
            $display("FAIL legal_pulses: clr/vld/abort got %0d/%0d/%0d, expected 1/1/0",
                     n_clr, n_vld, n_abort);
        end
        exp_q.delete();
    endtask

    task automatic test_illegal_op();
        bit to;
        clear_counts();
        push_resp(8'hEE, 16'hABCD);
        send_cmd(24'h09ABCD, to);
        wait_idle(to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL illegal_idle: %0d bytes outstanding, expected 0", exp_q.size());
        end
        vectors++;
        if (n_clr != 1 || n_vld != 0) begin
            errors++;
            $display("FAIL illegal_pulses: clr/vld got %0d/%0d, expected 1/0", n_clr, n_vld);
        end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        bit to;
        int vc, ac;
        clear_counts();
        push_resp(8'hEE, 16'h0000);
        send_cmd(24'h010000, to);
        wait_vld(to, vc);
        ac = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_abort) begin
                ac = cyc;
                break;
            end
        end
        vectors++;
        if (ac - vc != 16) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, expected 16", ac - vc);
        end
        wait_idle(to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL timeout_idle: %0d bytes outstanding, expected 0", exp_q.size());
        end
        vectors++;
        if (n_abort != 1) begin
            errors++;
            $display("FAIL timeout_abort: got %0d pulses, expected 1", n_abort);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit to, early;
        int vc;
        int left;
        clear_counts();
        push_resp(8'hA5, 16'h0001);
        push_resp(8'hEE, 16'h0002);
        send_cmd(24'h020001, to);
        wait_vld(to, vc);
        cmd = 24'h040002;
        cmd_rdy = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) early = 1'b1;
        end
        vectors++;
        if (early) begin
            errors++;
            $display("FAIL b2b_busy_clr: got clr_cmd_rdy while busy, expected none");
        end
        pulse_done(1'b0);
        left = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) begin
                left = exp_q.size();
                break;
            end
        end
        cmd_rdy = 1'b0;
        vectors++;
        if (left != NB) begin
            errors++;
            $display("FAIL b2b_order: %0d bytes left at second clr, expected %0d", left, NB);
        end
        wait_vld(to, vc);
        vectors++;
        if (to || opcode !== 8'h04 || operand !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_second: got op %h/%h, expected 04/0002", opcode, operand);
        end
        repeat (2) @(negedge clk);
        pulse_done(1'b1);
        wait_idle(to);
        vectors++;
        if (to || n_clr != 2 || n_vld != 2) begin
            errors++;
            $display("FAIL b2b_end: left/clr/vld got %0d/%0d/%0d, expected 0/2/2",
                     exp_q.size(), n_clr, n_vld);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_tx();
        bit to;
        int vc;
        clear_counts();
        push_resp(8'hA5, 16'h0777);
        send_cmd(24'h050777, to);
        wait_vld(to, vc);
        pulse_done(1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trmt) break;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({clr_cmd_rdy, trmt, op_vld, op_abort, busy} !== 5'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_tx: got ctl %b data %h, expected 00000/00",
                     {clr_cmd_rdy, trmt, op_vld, op_abort, busy}, tx_data);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_counts();
        push_resp(8'hA5, 16'h0002);
        send_cmd(24'h060002, to);
        wait_vld(to, vc);
        repeat (3) @(negedge clk);
        pulse_done(1'b0);
        wait_idle(to);
        vectors++;
        if (to || n_clr != 1 || n_vld != 1) begin
            errors++;
            $display("FAIL rst_recover: left/clr/vld got %0d/%0d/%0d, expected 0/1/1",
                     exp_q.size(), n_clr, n_vld);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_legal_op();
        test_illegal_op();
        test_timeout();
        test_back_to_back();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
